// File: rtl/mac_qcnt_pkg.sv
// Shared types and constants for the GMAC descriptor-queue snoop block.
package mac_qcnt_pkg;

  localparam int unsigned QCNT_W = 4;
  localparam logic [QCNT_W-1:0] QCNT_MAX = 4'd15;

  typedef enum logic [1:0] {IDLE, ARMED, FIRE} rxi_state_t;

  // A programmed threshold of zero behaves as one.
  function automatic logic [QCNT_W-1:0] eff_thresh(input logic [3:0] thr);
    return (thr == 4'd0) ? 4'd1 : thr;
  endfunction

endpackage

// File: rtl/mac_qcnt_ctr.sv
// Per-queue pulse register, saturating shadow occupancy counter and sticky
// overflow/underflow flags.
module mac_qcnt_ctr
  import mac_qcnt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_ev,
  input  logic              dec_ev,
  input  logic              sts_clr,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic [QCNT_W-1:0] level,
  output logic              ovf,
  output logic              udf
);

  logic              inc_q, dec_q;
  logic [QCNT_W-1:0] level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ovf_set, udf_set;

  always_comb begin
    level_d = level_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (inc_ev && !dec_ev) begin
      if (level_q == QCNT_MAX) ovf_set = 1'b1;
      else                     level_d = level_q + 1'b1;
    end else if (dec_ev && !inc_ev) begin
      if (level_q == '0) udf_set = 1'b1;
      else               level_d = level_q - 1'b1;
    end
    // A new error wins over a clear arriving in the same cycle.
    ovf_d = ovf_set | (ovf_q & ~sts_clr);
    udf_d = udf_set | (udf_q & ~sts_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      inc_q   <= inc_ev;
      dec_q   <= dec_ev;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: rtl/mac_qcnt_snoop.sv
// Snoops completed descriptor-window accesses, drives mac_wrapper queue pulses,
// tracks shadow occupancy and raises a coalesced RX interrupt.
module mac_qcnt_snoop
  import mac_qcnt_pkg::*;
#(
  parameter int unsigned QBASE_W = 10,
  parameter int unsigned TMR_W   = 12
) (
  input  logic               app_clk,
  input  logic               reset,
  input  logic               cfg_qcnt_en,
  input  logic [QBASE_W-1:0] cfg_tx_qbase_addr,
  input  logic [QBASE_W-1:0] cfg_rx_qbase_addr,
  input  logic [3:0]         cfg_intr_thresh,
  input  logic [TMR_W-1:0]   cfg_intr_timeout,
  input  logic [15:0]        wb_xram_adr,
  input  logic [3:0]         wb_xram_sel,
  input  logic               wb_xram_we,
  input  logic               wb_xram_stb,
  input  logic               wb_xram_ack,
  input  logic               sts_clr,
  output logic               mac_tx_qcnt_inc,
  output logic               mac_tx_qcnt_dec,
  output logic               mac_rx_qcnt_inc,
  output logic               mac_rx_qcnt_dec,
  output logic [QCNT_W-1:0]  tx_qlevel,
  output logic [QCNT_W-1:0]  rx_qlevel,
  output logic               sts_tx_ovf,
  output logic               sts_tx_udf,
  output logic               sts_rx_ovf,
  output logic               sts_rx_udf,
  output logic               mac_rx_intr
);

  logic [QBASE_W-1:0] adr_base;
  logic               bus_ev, tx_hit, rx_hit;
  logic               unused_bus;

  // Only the byte lane carrying the descriptor ownership word qualifies.
  assign bus_ev     = wb_xram_stb & wb_xram_ack & wb_xram_sel[3] & cfg_qcnt_en;
  assign adr_base   = QBASE_W'(wb_xram_adr[15:6]);
  assign tx_hit     = bus_ev & (adr_base == cfg_tx_qbase_addr);
  assign rx_hit     = bus_ev & (adr_base == cfg_rx_qbase_addr);
  assign unused_bus = ^{wb_xram_adr[5:0], wb_xram_sel[2:0]};

  mac_qcnt_ctr u_tx_ctr (
    .clk       (app_clk),
    .reset     (reset),
    .inc_ev    (tx_hit & wb_xram_we),
    .dec_ev    (tx_hit & ~wb_xram_we),
    .sts_clr   (sts_clr),
    .inc_pulse (mac_tx_qcnt_inc),
    .dec_pulse (mac_tx_qcnt_dec),
    .level     (tx_qlevel),
    .ovf       (sts_tx_ovf),
    .udf       (sts_tx_udf)
  );

  mac_qcnt_ctr u_rx_ctr (
    .clk       (app_clk),
    .reset     (reset),
    .inc_ev    (rx_hit & wb_xram_we),
    .dec_ev    (rx_hit & ~wb_xram_we),
    .sts_clr   (sts_clr),
    .inc_pulse (mac_rx_qcnt_inc),
    .dec_pulse (mac_rx_qcnt_dec),
    .level     (rx_qlevel),
    .ovf       (sts_rx_ovf),
    .udf       (sts_rx_udf)
  );

  rxi_state_t        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [QCNT_W-1:0] thr;

  assign thr = eff_thresh(cfg_intr_thresh);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!cfg_qcnt_en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_qlevel != '0) begin
            state_d = ARMED;
            timer_d = '0;
          end
        end
        ARMED: begin
          if (timer_q != '1) timer_d = timer_q + 1'b1;
          // Fire conditions take precedence over the queue draining.
          if (rx_qlevel >= thr || timer_q >= cfg_intr_timeout) state_d = FIRE;
          else if (rx_qlevel == '0)                            state_d = IDLE;
        end
        FIRE: begin
          if (rx_qlevel == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign mac_rx_intr = cfg_qcnt_en & (state_q == FIRE);

endmodule

// File: tb/tb_mac_qcnt_snoop.sv
// Directed self-checking bench for mac_qcnt_snoop.
module tb_mac_qcnt_snoop;

  logic        app_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_qcnt_en = 1'b1;
  logic [9:0]  cfg_tx_qbase_addr = 10'h010;
  logic [9:0]  cfg_rx_qbase_addr = 10'h020;
  logic [3:0]  cfg_intr_thresh = 4'd15;
  logic [11:0] cfg_intr_timeout = 12'hfff;
  logic [15:0] wb_xram_adr = '0;
  logic [3:0]  wb_xram_sel = '0;
  logic        wb_xram_we = 1'b0;
  logic        wb_xram_stb = 1'b0;
  logic        wb_xram_ack = 1'b0;
  logic        sts_clr = 1'b0;
  logic        mac_tx_qcnt_inc, mac_tx_qcnt_dec, mac_rx_qcnt_inc, mac_rx_qcnt_dec;
  logic [3:0]  tx_qlevel, rx_qlevel;
  logic        sts_tx_ovf, sts_tx_udf, sts_rx_ovf, sts_rx_udf, mac_rx_intr;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] TxAdr = 16'h0400;
  localparam logic [15:0] RxAdr = 16'h0800;

  always #5 app_clk = ~app_clk;

  mac_qcnt_snoop dut (
    .app_clk           (app_clk),
    .reset             (reset),
    .cfg_qcnt_en       (cfg_qcnt_en),
    .cfg_tx_qbase_addr (cfg_tx_qbase_addr),
    .cfg_rx_qbase_addr (cfg_rx_qbase_addr),
    .cfg_intr_thresh   (cfg_intr_thresh),
    .cfg_intr_timeout  (cfg_intr_timeout),
    .wb_xram_adr       (wb_xram_adr),
    .wb_xram_sel       (wb_xram_sel),
    .wb_xram_we        (wb_xram_we),
    .wb_xram_stb       (wb_xram_stb),
    .wb_xram_ack       (wb_xram_ack),
    .sts_clr           (sts_clr),
    .mac_tx_qcnt_inc   (mac_tx_qcnt_inc),
    .mac_tx_qcnt_dec   (mac_tx_qcnt_dec),
    .mac_rx_qcnt_inc   (mac_rx_qcnt_inc),
    .mac_rx_qcnt_dec   (mac_rx_qcnt_dec),
    .tx_qlevel         (tx_qlevel),
    .rx_qlevel         (rx_qlevel),
    .sts_tx_ovf        (sts_tx_ovf),
    .sts_tx_udf        (sts_tx_udf),
    .sts_rx_ovf        (sts_rx_ovf),
    .sts_rx_udf        (sts_rx_udf),
    .mac_rx_intr       (mac_rx_intr)
  );

  // Advance to 1 ns after the next rising edge; inputs and samples change there.
  task automatic cyc();
    @(posedge app_clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] adr, input logic we, input logic [3:0] sel);
    wb_xram_adr = adr;
    wb_xram_we  = we;
    wb_xram_sel = sel;
    wb_xram_stb = 1'b1;
    wb_xram_ack = 1'b1;
  endtask

  task automatic idle_bus();
    wb_xram_stb = 1'b0;
    wb_xram_ack = 1'b0;
  endtask

  // One qualified-or-not bus cycle; returns in the cycle after the event.
  task automatic bus_ev(input logic [15:0] adr, input logic we, input logic [3:0] sel);
    drive(adr, we, sel);
    cyc();
    idle_bus();
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_cmp++; if ({mac_tx_qcnt_inc, mac_tx_qcnt_dec, mac_rx_qcnt_inc, mac_rx_qcnt_dec} !== 4'b0)
      begin n_err++; $display("FAIL reset_pulses: got %b want 0000",
        {mac_tx_qcnt_inc, mac_tx_qcnt_dec, mac_rx_qcnt_inc, mac_rx_qcnt_dec}); end
    n_cmp++; if ({tx_qlevel, rx_qlevel} !== 8'h00)
      begin n_err++; $display("FAIL reset_levels: got %h want 00", {tx_qlevel, rx_qlevel}); end
    n_cmp++; if ({sts_tx_ovf, sts_tx_udf, sts_rx_ovf, sts_rx_udf, mac_rx_intr} !== 5'b0)
      begin n_err++; $display("FAIL reset_flags: got %b want 00000",
        {sts_tx_ovf, sts_tx_udf, sts_rx_ovf, sts_rx_udf, mac_rx_intr}); end
  endtask

  task automatic test_tx_inc();
    bus_ev(TxAdr, 1'b1, 4'b1000);
    n_cmp++; if (mac_tx_qcnt_inc !== 1'b1)
      begin n_err++; $display("FAIL tx_inc_pulse: got %b want 1", mac_tx_qcnt_inc); end
    n_cmp++; if (tx_qlevel !== 4'd1)
      begin n_err++; $display("FAIL tx_level_1: got %0d want 1", tx_qlevel); end
    n_cmp++; if (mac_rx_qcnt_inc !== 1'b0)
      begin n_err++; $display("FAIL tx_no_rx_inc: got %b want 0", mac_rx_qcnt_inc); end
    cyc();
    n_cmp++; if (mac_tx_qcnt_inc !== 1'b0)
      begin n_err++; $display("FAIL tx_inc_one_cycle: got %b want 0", mac_tx_qcnt_inc); end
    bus_ev(TxAdr, 1'b1, 4'b0111);
    n_cmp++; if (mac_tx_qcnt_inc !== 1'b0 || tx_qlevel !== 4'd1)
      begin n_err++; $display("FAIL tx_sel_filter: got inc=%b lvl=%0d want inc=0 lvl=1",
        mac_tx_qcnt_inc, tx_qlevel); end
    cfg_qcnt_en = 1'b0;
    bus_ev(TxAdr, 1'b1, 4'b1000);
    n_cmp++; if (mac_tx_qcnt_inc !== 1'b0 || tx_qlevel !== 4'd1)
      begin n_err++; $display("FAIL tx_disabled: got inc=%b lvl=%0d want inc=0 lvl=1",
        mac_tx_qcnt_inc, tx_qlevel); end
    cfg_qcnt_en = 1'b1;
  endtask

  task automatic test_tx_udf();
    bus_ev(TxAdr, 1'b0, 4'b1000);
    n_cmp++; if (mac_tx_qcnt_dec !== 1'b1 || tx_qlevel !== 4'd0 || sts_tx_udf !== 1'b0)
      begin n_err++; $display("FAIL tx_dec_to_0: got dec=%b lvl=%0d udf=%b want 1 0 0",
        mac_tx_qcnt_dec, tx_qlevel, sts_tx_udf); end
    bus_ev(TxAdr, 1'b0, 4'b1000);
    n_cmp++; if (mac_tx_qcnt_dec !== 1'b1 || tx_qlevel !== 4'd0 || sts_tx_udf !== 1'b1)
      begin n_err++; $display("FAIL tx_udf: got dec=%b lvl=%0d udf=%b want 1 0 1",
        mac_tx_qcnt_dec, tx_qlevel, sts_tx_udf); end
    cyc();
    n_cmp++; if (sts_tx_udf !== 1'b1)
      begin n_err++; $display("FAIL tx_udf_sticky: got %b want 1", sts_tx_udf); end
    sts_clr = 1'b1;
    bus_ev(TxAdr, 1'b0, 4'b1000);
    n_cmp++; if (sts_tx_udf !== 1'b1)
      begin n_err++; $display("FAIL tx_udf_set_over_clr: got %b want 1", sts_tx_udf); end
    cyc();
    sts_clr = 1'b0;
    n_cmp++; if (sts_tx_udf !== 1'b0)
      begin n_err++; $display("FAIL tx_udf_clr: got %b want 0", sts_tx_udf); end
  endtask

  task automatic test_rx_ovf();
    int npulse = 0;
    drive(RxAdr, 1'b1, 4'b1000);
    for (int i = 0; i < 17; i++) begin
      cyc();
      npulse += int'(mac_rx_qcnt_inc);
      if (i == 14) begin
        n_cmp++; if (rx_qlevel !== 4'd15 || sts_rx_ovf !== 1'b0)
          begin n_err++; $display("FAIL rx_full_no_ovf: got lvl=%0d ovf=%b want 15 0",
            rx_qlevel, sts_rx_ovf); end
      end
    end
    idle_bus();
    cyc();
    n_cmp++; if (npulse !== 17)
      begin n_err++; $display("FAIL rx_inc_count: got %0d want 17", npulse); end
    n_cmp++; if (rx_qlevel !== 4'd15 || sts_rx_ovf !== 1'b1 || mac_rx_qcnt_inc !== 1'b0)
      begin n_err++; $display("FAIL rx_ovf: got lvl=%0d ovf=%b inc=%b want 15 1 0",
        rx_qlevel, sts_rx_ovf, mac_rx_qcnt_inc); end
    sts_clr = 1'b1;
    cyc();
    sts_clr = 1'b0;
    n_cmp++; if (sts_rx_ovf !== 1'b0 || rx_qlevel !== 4'd15)
      begin n_err++; $display("FAIL rx_ovf_clr: got ovf=%b lvl=%0d want 0 15",
        sts_rx_ovf, rx_qlevel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_rx_qbase_addr = 10'h010;
    drive(TxAdr, 1'b1, 4'b1000);
    cyc();
    n_cmp++; if ({mac_tx_qcnt_inc, mac_rx_qcnt_inc} !== 2'b11 || {tx_qlevel, rx_qlevel} !== 8'h11)
      begin n_err++; $display("FAIL shared_inc: got inc=%b lvl=%h want 11 11",
        {mac_tx_qcnt_inc, mac_rx_qcnt_inc}, {tx_qlevel, rx_qlevel}); end
    wb_xram_we = 1'b0;
    cyc();
    idle_bus();
    n_cmp++; if ({mac_tx_qcnt_dec, mac_rx_qcnt_dec, mac_rx_qcnt_inc} !== 3'b110)
      begin n_err++; $display("FAIL shared_dec: got %b want 110",
        {mac_tx_qcnt_dec, mac_rx_qcnt_dec, mac_rx_qcnt_inc}); end
    n_cmp++; if ({tx_qlevel, rx_qlevel} !== 8'h00)
      begin n_err++; $display("FAIL shared_level: got %h want 00", {tx_qlevel, rx_qlevel}); end
    cyc();
    n_cmp++; if ({sts_tx_ovf, sts_tx_udf, sts_rx_ovf, sts_rx_udf} !== 4'b0)
      begin n_err++; $display("FAIL shared_flags: got %b want 0000",
        {sts_tx_ovf, sts_tx_udf, sts_rx_ovf, sts_rx_udf}); end
    cfg_rx_qbase_addr = 10'h020;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    do_reset();
    cfg_intr_thresh  = 4'd4;
    cfg_intr_timeout = 12'd100;
    bus_ev(RxAdr, 1'b1, 4'b1000);
    n_cmp++; if (mac_rx_intr !== 1'b0)
      begin n_err++; $display("FAIL tmo_early: got %b want 0", mac_rx_intr); end
    while (mac_rx_intr !== 1'b1 && cnt < 200) begin
      cyc();
      cnt++;
    end
    // ARMED one cycle after the level update, then fire 101 cycles later.
    n_cmp++; if (cnt !== 102)
      begin n_err++; $display("FAIL tmo_latency: got %0d want 102", cnt); end
    bus_ev(RxAdr, 1'b0, 4'b1000);
    n_cmp++; if (rx_qlevel !== 4'd0 || mac_rx_intr !== 1'b1)
      begin n_err++; $display("FAIL tmo_drain: got lvl=%0d intr=%b want 0 1",
        rx_qlevel, mac_rx_intr); end
    cyc();
    n_cmp++; if (mac_rx_intr !== 1'b0)
      begin n_err++; $display("FAIL tmo_fall: got %b want 0", mac_rx_intr); end
  endtask

  task automatic test_threshold();
    do_reset();
    cfg_intr_thresh  = 4'd0;
    cfg_intr_timeout = 12'hfff;
    bus_ev(RxAdr, 1'b1, 4'b1000);
    cyc();
    n_cmp++; if (mac_rx_intr !== 1'b0)
      begin n_err++; $display("FAIL thr0_armed: got %b want 0", mac_rx_intr); end
    cyc();
    n_cmp++; if (mac_rx_intr !== 1'b1)
      begin n_err++; $display("FAIL thr0_fire: got %b want 1", mac_rx_intr); end
    cfg_qcnt_en = 1'b0;
    #1;
    n_cmp++; if (mac_rx_intr !== 1'b0)
      begin n_err++; $display("FAIL en_off_intr: got %b want 0", mac_rx_intr); end
    cfg_qcnt_en = 1'b1;

    do_reset();
    cfg_intr_thresh = 4'd2;
    drive(RxAdr, 1'b1, 4'b1000);
    cyc();
    cyc();
    idle_bus();
    n_cmp++; if (rx_qlevel !== 4'd2 || mac_rx_intr !== 1'b0)
      begin n_err++; $display("FAIL thr2_level: got lvl=%0d intr=%b want 2 0",
        rx_qlevel, mac_rx_intr); end
    cyc();
    n_cmp++; if (mac_rx_intr !== 1'b1)
      begin n_err++; $display("FAIL thr2_fire: got %b want 1", mac_rx_intr); end
    reset = 1'b1;
    drive(RxAdr, 1'b1, 4'b1000);
    cyc();
    idle_bus();
    reset = 1'b0;
    n_cmp++; if ({mac_rx_qcnt_inc, mac_rx_intr, sts_rx_ovf} !== 3'b0 || rx_qlevel !== 4'd0)
      begin n_err++; $display("FAIL fire_reset: got inc/intr/ovf=%b lvl=%0d want 000 0",
        {mac_rx_qcnt_inc, mac_rx_intr, sts_rx_ovf}, rx_qlevel); end
    cyc();
    n_cmp++; if (mac_rx_intr !== 1'b0 || rx_qlevel !== 4'd0)
      begin n_err++; $display("FAIL post_reset: got intr=%b lvl=%0d want 0 0",
        mac_rx_intr, rx_qlevel); end
  endtask

  initial begin
    test_reset();
    test_tx_inc();
    test_tx_udf();
    test_rx_ovf();
    test_back_to_back();
    test_timeout();
    test_threshold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
